// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM-stage data memory with byte-lane stores, registered word loads and a
// power-on clear FSM. Optional store logging under macro DM_WRITE_LOG_EN.
`default_nettype none

module data_mem_stage #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  st_type,
    input  logic [2:0]  ld_type,
    output logic [31:0] rdata,
    output logic [1:0]  byte_sel_out,
    output logic [2:0]  ld_type_out,
    output logic        busy,
    output logic        addr_err
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [31:0]           mem [0:DEPTH-1];

    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  bad_kind;
    logic                  illegal;
    logic                  store_ok;
    logic                  load_ok;
    logic [3:0]            be;
    logic [31:0]           wd;

    assign offset   = addr - BASE_ADDR;
    assign in_range = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
    assign idx      = offset[ADDR_WIDTH+1:2];

    // Alignment and reserved-encoding checks depend on access direction.
    always_comb begin
        bad_kind = 1'b0;
        if (we) begin
            case (st_type)
                2'b00:   bad_kind = (addr[1:0] != 2'b00);
                2'b01:   bad_kind = addr[0];
                2'b10:   bad_kind = 1'b0;
                default: bad_kind = 1'b1;
            endcase
        end else begin
            case (ld_type)
                3'b000:         bad_kind = (addr[1:0] != 2'b00);
                3'b001, 3'b010: bad_kind = addr[0];
                3'b011, 3'b100: bad_kind = 1'b0;
                default:        bad_kind = 1'b1;
            endcase
        end
    end

    assign illegal  = ~in_range | bad_kind;
    assign store_ok = (state == ST_RUN) & en &  we & ~illegal;
    assign load_ok  = (state == ST_RUN) & en & ~we & ~illegal;

    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (st_type)
            2'b00: begin
                be = 4'b1111;
                wd = wdata;
            end
            2'b01: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b0001 << addr[1:0];
                wd = {4{wdata[7:0]}};
            end
            default: begin
                be = 4'b0000;
                wd = wdata;
            end
        endcase
    end

    // Array has no reset; it is zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_CLEAR;
            clr_idx      <= '0;
            busy         <= 1'b1;
            rdata        <= '0;
            byte_sel_out <= '0;
            ld_type_out  <= '0;
            addr_err     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    addr_err <= 1'b0;
                    clr_idx  <= clr_idx + ADDR_WIDTH'(1);
                    if (clr_idx == LAST_IDX) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    addr_err <= en & illegal;
                    if (load_ok) begin
                        rdata        <= mem[idx];
                        byte_sel_out <= addr[1:0];
                        ld_type_out  <= ld_type;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] log_mask;
    logic [31:0] log_word;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            log_mask[8*b +: 8] = {8{be[b]}};
        end
        log_word = (mem[idx] & ~log_mask) | (wd & log_mask);
    end

    always @(posedge clk) begin
        if (store_ok) begin
            $display("%t: *%h <= %h", $time, BASE_ADDR + 32'({idx, 2'b00}), log_word);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: directed self-checking bench for data_mem_stage with a 16-word array.
`default_nettype none

module tb_data_mem_stage;

    localparam int AW    = 4;
    localparam int WORDS = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st_type;
    logic [2:0]  ld_type;
    logic [31:0] rdata;
    logic [1:0]  byte_sel_out;
    logic [2:0]  ld_type_out;
    logic        busy;
    logic        addr_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model    [WORDS];
    logic [31:0] rd_words [WORDS];

    data_mem_stage #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .st_type     (st_type),
        .ld_type     (ld_type),
        .rdata       (rdata),
        .byte_sel_out(byte_sel_out),
        .ld_type_out (ld_type_out),
        .busy        (busy),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        en = 1'b1; we = 1'b1; addr = a; wdata = d; st_type = st;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] lt);
        en = 1'b1; we = 1'b0; addr = a; ld_type = lt;
        tick();
        en = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < WORDS; i++) begin
            do_load(32'(i * 4), 3'b000);
            rd_words[i] = rdata;
        end
    endtask

    // Counts edges after reset release until busy drops; returns 999 if it never does.
    task automatic wait_clear(output int cycles);
        cycles = 999;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!busy) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        int err_seen;
        reset_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        st_type = '0; ld_type = '0;
        tick(); tick();
        checks++;
        if (rdata !== 32'h0 || byte_sel_out !== 2'b00 || ld_type_out !== 3'b000 ||
            busy !== 1'b1 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h bsel=%b ldt=%b busy=%b err=%b, want 0/0/0/1/0",
                     rdata, byte_sel_out, ld_type_out, busy, addr_err);
        end
        reset_n = 1'b1;
        // Hammer accesses during clear: a store and an out-of-range request must both be ignored.
        en = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hFFFF_FFFF; st_type = 2'b00;
        cyc = 999;
        err_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            addr = (i % 2 == 0) ? 32'h0 : 32'h0000_0100;
            if (addr_err) err_seen = 1;
            if (!busy) begin
                cyc = i;
                break;
            end
        end
        en = 1'b0; we = 1'b0;
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL clear_duration: busy cycles=%0d, want 16", cyc);
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL clear_addr_err: addr_err seen during clear=%0d, want 0", err_seen);
        end
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        read_all();
        for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (rd_words[i] !== model[i]) begin
                errors++;
                $display("FAIL clear_word%0d: got %h, want %h", i, rd_words[i], model[i]);
            end
        end
    endtask

    task automatic test_sw_lw();
        do_store(32'h8, 32'h1234_5678, 2'b00);
        model[2] = 32'h1234_5678;
        do_load(32'h8, 3'b000);
        checks++;
        if (rdata !== 32'h1234_5678 || byte_sel_out !== 2'b00 || ld_type_out !== 3'b000 ||
            addr_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_lw: rdata=%h bsel=%b ldt=%b err=%b, want 12345678/00/000/0",
                     rdata, byte_sel_out, ld_type_out, addr_err);
        end
    endtask

    task automatic test_merge();
        do_store(32'hA, 32'hFFFF_FFAB, 2'b10);
        do_store(32'h8, 32'hFFFF_CDEF, 2'b01);
        model[2] = 32'h12AB_CDEF;
        do_load(32'h8, 3'b000);
        checks++;
        if (rdata !== 32'h12AB_CDEF) begin
            errors++;
            $display("FAIL merge_lw: rdata=%h, want 12abcdef", rdata);
        end
        do_store(32'h16, 32'h0000_BEEF, 2'b01);
        model[5] = 32'hBEEF_0000;
        do_load(32'h17, 3'b011);
        checks++;
        if (rdata !== 32'hBEEF_0000 || byte_sel_out !== 2'b11 || ld_type_out !== 3'b011) begin
            errors++;
            $display("FAIL merge_upper_half: rdata=%h bsel=%b ldt=%b, want beef0000/11/011",
                     rdata, byte_sel_out, ld_type_out);
        end
    endtask

    task automatic test_illegal();
        do_load(32'h9, 3'b010);
        checks++;
        if (addr_err !== 1'b1 || rdata !== 32'hBEEF_0000 || byte_sel_out !== 2'b11 ||
            ld_type_out !== 3'b011) begin
            errors++;
            $display("FAIL lh_misaligned: err=%b rdata=%h bsel=%b ldt=%b, want 1/beef0000/11/011",
                     addr_err, rdata, byte_sel_out, ld_type_out);
        end
        tick();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: addr_err=%b after idle, want 0", addr_err);
        end
        do_store(32'h41, 32'h0000_0004, 2'b00);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL sw_out_of_range: addr_err=%b, want 1", addr_err);
        end
        do_store(32'h6, 32'hDEAD_BEEF, 2'b00);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL sw_misaligned: addr_err=%b, want 1", addr_err);
        end
        do_store(32'h4, 32'hDEAD_BEEF, 2'b11);
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL st_type_reserved: addr_err=%b, want 1", addr_err);
        end
        do_store(32'h3C, 32'h0000_1111, 2'b10);
        model[15] = 32'h0000_0011;
        do_load(32'h0, 3'b101);
        checks++;
        if (addr_err !== 1'b1 || rdata !== 32'hBEEF_0000) begin
            errors++;
            $display("FAIL ld_type_reserved: err=%b rdata=%h, want 1/beef0000", addr_err, rdata);
        end
        read_all();
        for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (rd_words[i] !== model[i]) begin
                errors++;
                $display("FAIL illegal_array_word%0d: got %h, want %h", i, rd_words[i], model[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; we = 1'b1; addr = 32'hC; wdata = 32'h0000_005A; st_type = 2'b10;
        tick();
        we = 1'b0; ld_type = 3'b011;
        tick();
        en = 1'b0;
        model[3] = 32'h0000_005A;
        checks++;
        if (rdata !== 32'h0000_005A || byte_sel_out !== 2'b00 || ld_type_out !== 3'b011) begin
            errors++;
            $display("FAIL back_to_back: rdata=%h bsel=%b ldt=%b, want 0000005a/00/011",
                     rdata, byte_sel_out, ld_type_out);
        end
    endtask

    task automatic test_reset_restart();
        int cyc;
        do_load(32'h3E, 3'b001);
        #2;
        reset_n = 1'b0;
        #2;
        checks++;
        if (rdata !== 32'h0 || byte_sel_out !== 2'b00 || ld_type_out !== 3'b000 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_run: rdata=%h bsel=%b ldt=%b busy=%b, want 0/0/0/1",
                     rdata, byte_sel_out, ld_type_out, busy);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy: busy=%b at cycle 5, want 1", busy);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_clear(cyc);
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL restart_duration: busy cycles=%0d, want 16", cyc);
        end
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        read_all();
        for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (rd_words[i] !== model[i]) begin
                errors++;
                $display("FAIL restart_word%0d: got %h, want %h", i, rd_words[i], model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_merge();
        test_illegal();
        test_back_to_back();
        test_reset_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
